// File: rtl/iob_mem_arbiter.sv
// rtl/iob_mem_arbiter.sv - two-requester round-robin arbiter onto one native memory port with slave timeout
module iob_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    output logic                m0_err,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                m1_err,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready,

    output logic                grant,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    // A zero-width counter is illegal, so a disabled timeout still keeps one bit.
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last allowed ACCESS cycle; that cycle's increment reaches TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic             TO_EN    = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                owner;
    logic                last_grant;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt;

    logic                any_valid;
    logic                win;
    logic                timeout_hit;
    logic                resp_active;

    assign any_valid   = m0_valid | m1_valid;
    assign timeout_hit = TO_EN & (cnt == CNT_LAST);

    // Round-robin pick: a lone requester wins outright, a tie goes to whoever was not granted last.
    always_comb begin
        win = 1'b0;
        if (m0_valid && m1_valid) begin
            win = ~last_grant;
        end else if (m1_valid) begin
            win = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RESP always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (s_ready || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture at grant, response capture at slave completion or timeout, wait counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner      <= win;
                        last_grant <= win;
                        addr_q     <= win ? m1_addr  : m0_addr;
                        wdata_q    <= win ? m1_wdata : m0_wdata;
                        wstrb_q    <= win ? m1_wstrb : m0_wstrb;
                        cnt        <= '0;
                    end
                end
                ACCESS: begin
                    // A real answer beats a simultaneous timeout.
                    if (s_ready) begin
                        rdata_q <= s_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_active = (state == RESP);

    assign s_valid  = (state == ACCESS);
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;

    // Response data and error are forced to zero whenever the matching ready is low.
    assign m0_ready = resp_active & ~owner;
    assign m0_rdata = m0_ready ? rdata_q : '0;
    assign m0_err   = m0_ready & err_q;

    assign m1_ready = resp_active & owner;
    assign m1_rdata = m1_ready ? rdata_q : '0;
    assign m1_err   = m1_ready & err_q;

    assign grant    = owner;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// tb/tb_iob_mem_arbiter.sv - randomized and directed bench for iob_mem_arbiter
module tb_iob_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;

    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        grant, busy;

    logic        z_m0_valid, z_m1_valid;
    logic [31:0] z_m0_addr, z_m0_wdata, z_m1_addr, z_m1_wdata;
    logic [3:0]  z_m0_wstrb, z_m1_wstrb;
    logic [31:0] z_m0_rdata, z_m1_rdata;
    logic        z_m0_ready, z_m0_err, z_m1_ready, z_m1_err;
    logic        z_s_valid, z_s_ready;
    logic [31:0] z_s_addr, z_s_wdata, z_s_rdata;
    logic [3:0]  z_s_wstrb;
    logic        z_grant, z_busy;

    always #5 clk = ~clk;

    iob_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .busy(busy)
    );

    iob_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_nto (
        .clk(clk), .rst(rst),
        .m0_valid(z_m0_valid), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata), .m0_wstrb(z_m0_wstrb),
        .m0_rdata(z_m0_rdata), .m0_ready(z_m0_ready), .m0_err(z_m0_err),
        .m1_valid(z_m1_valid), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata), .m1_wstrb(z_m1_wstrb),
        .m1_rdata(z_m1_rdata), .m1_ready(z_m1_ready), .m1_err(z_m1_err),
        .s_valid(z_s_valid), .s_addr(z_s_addr), .s_wdata(z_s_wdata), .s_wstrb(z_s_wstrb),
        .s_rdata(z_s_rdata), .s_ready(z_s_ready),
        .grant(z_grant), .busy(z_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side view: which requests are outstanding and what they carry.
    logic        pend [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_wstrb [2];
    int          model_last;
    int          obs_grant;

    task automatic apply();
        m0_valid = pend[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0]; m0_wstrb = r_wstrb[0];
        m1_valid = pend[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1]; m1_wstrb = r_wstrb[1];
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        r_addr[i] = a; r_wdata[i] = wd; r_wstrb[i] = ws; pend[i] = 1'b1;
        apply();
    endtask

    task automatic rand_req(input int i);
        if (!pend[i]) begin
            set_req(i, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        apply();
        s_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_last = 1;
    endtask

    // One transaction from an IDLE negedge: slave answers in ACCESS cycle d (d > TO means never).
    task automatic run_txn(input int d, input logic [31:0] rd);
        int          w;
        int          lim;
        logic        timed_out;
        logic        g_rdy [2];
        logic        g_err [2];
        logic [31:0] g_rd [2];
        if (pend[0] && pend[1]) w = 1 - model_last;
        else                    w = pend[0] ? 0 : 1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_s_valid", s_valid, 1'b0);
        @(negedge clk);
        model_last = w;
        obs_grant  = int'(grant);
        chk("grant", grant, w[0]);
        chk("access_busy", busy, 1'b1);
        timed_out = (d > TO);
        lim = timed_out ? TO : d;
        for (int i = 1; i <= lim; i++) begin
            chk("s_valid", s_valid, 1'b1);
            chk("s_addr", s_addr, r_addr[w]);
            chk("s_wdata", s_wdata, r_wdata[w]);
            chk("s_wstrb", s_wstrb, r_wstrb[w]);
            chk("early_ready", {m0_ready, m1_ready}, 2'b00);
            if (!pend[1 - w] && $urandom_range(0, 3) == 0) rand_req(1 - w);
            if (i == d) begin
                s_ready = 1'b1;
                s_rdata = rd;
            end
            @(negedge clk);
            s_ready = 1'b0;
            s_rdata = $urandom;
        end
        g_rdy[0] = m0_ready; g_err[0] = m0_err; g_rd[0] = m0_rdata;
        g_rdy[1] = m1_ready; g_err[1] = m1_err; g_rd[1] = m1_rdata;
        chk("resp_s_valid", s_valid, 1'b0);
        chk("resp_ready", g_rdy[w], 1'b1);
        chk("resp_rdata", g_rd[w], timed_out ? 32'h0 : rd);
        chk("resp_err", g_err[w], timed_out);
        chk("other_quiet", {g_rdy[1 - w], g_err[1 - w], g_rd[1 - w]}, 34'h0);
        pend[w] = 1'b0;
        apply();
        @(negedge clk);
        chk("after_resp_ready", {m0_ready, m1_ready}, 2'b00);
    endtask

    logic z_bad;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        s_ready = 1'b0; s_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0;
        end
        apply();
        z_m0_valid = 1'b0; z_m0_addr = '0; z_m0_wdata = '0; z_m0_wstrb = '0;
        z_m1_valid = 1'b0; z_m1_addr = '0; z_m1_wdata = '0; z_m1_wstrb = '0;
        z_s_ready = 1'b0; z_s_rdata = '0;
        obs_grant = -1;
        do_reset();

        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_m0", {m0_ready, m0_err, m0_rdata}, 34'h0);
        chk("rst_m1", {m1_ready, m1_err, m1_rdata}, 34'h0);
        chk("rst_s_req", {s_addr, s_wdata, s_wstrb}, 64'h0);

        // Single read.
        set_req(0, 32'h100, 32'h0, 4'h0);
        run_txn(3, 32'hDEADBEEF);

        // Contention straight out of reset: m0, then m1, then m0 again on a fresh tie.
        do_reset();
        set_req(0, $urandom, $urandom, 4'h0);
        set_req(1, $urandom, $urandom, 4'h3);
        run_txn(2, $urandom);
        chk("contend_first", obs_grant, 0);
        run_txn(1, $urandom);
        chk("contend_second", obs_grant, 1);
        set_req(0, $urandom, $urandom, 4'h0);
        set_req(1, $urandom, $urandom, 4'h0);
        run_txn(2, $urandom);
        chk("contend_again", obs_grant, 0);
        pend[1] = 1'b0; apply();

        // Write from m1 held over several ACCESS cycles.
        set_req(1, 32'h40, 32'h12345678, 4'hF);
        run_txn(3, $urandom);

        // Timeout, then answer in the very last allowed cycle.
        set_req(0, $urandom, $urandom, 4'h0);
        run_txn(TO + 5, 32'h5555AAAA);
        set_req(0, $urandom, $urandom, 4'h0);
        run_txn(TO, 32'hCAFEF00D);

        // Reset in the middle of ACCESS: no response, m1 served first afterwards.
        do_reset();
        set_req(0, $urandom, $urandom, 4'h0);
        set_req(1, $urandom, $urandom, 4'h1);
        @(negedge clk);
        chk("midrst_owner", grant, 1'b0);
        chk("midrst_access", s_valid, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_s_valid", s_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", {m0_ready, m1_ready}, 2'b00);
        pend[0] = 1'b0;
        apply();
        @(negedge clk);
        chk("midrst_hold_ready", {m0_ready, m1_ready}, 2'b00);
        rst = 1'b1;
        model_last = 1;
        run_txn(2, $urandom);
        chk("midrst_m1_first", obs_grant, 1);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0) begin
                s_ready = 1'b1;
                s_rdata = $urandom;
                @(negedge clk);
                s_ready = 1'b0;
                chk("stray_busy", busy, 1'b0);
                chk("stray_s_valid", s_valid, 1'b0);
                chk("stray_ready", {m0_ready, m1_ready}, 2'b00);
            end
            if ($urandom_range(0, 1) == 1) rand_req(0);
            if ($urandom_range(0, 1) == 1) rand_req(1);
            if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
            run_txn(int'($urandom_range(1, TO + 2)), $urandom);
        end

        // Disabled timeout: a long stall must keep waiting without an error.
        z_bad = 1'b0;
        z_m0_valid = 1'b1; z_m0_addr = 32'h200; z_m0_wdata = '0; z_m0_wstrb = 4'h0;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (z_s_valid !== 1'b1 || z_m0_ready !== 1'b0 || z_m0_err !== 1'b0 || z_m1_ready !== 1'b0)
                z_bad = 1'b1;
        end
        chk("nto_still_waiting", z_s_valid, 1'b1);
        chk("nto_quiet", z_bad, 1'b0);
        z_s_ready = 1'b1;
        z_s_rdata = 32'h0BADF00D;
        @(negedge clk);
        z_s_ready = 1'b0;
        z_m0_valid = 1'b0;
        chk("nto_ready", z_m0_ready, 1'b1);
        chk("nto_rdata", z_m0_rdata, 32'h0BADF00D);
        chk("nto_err", z_m0_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
